// File: rtl/vid_timing_pkg.sv
// Shared types and constants for the parametrised CRTC timing generator.
// Default geometry, the shadowed timing set, and the dither phase rule.
package vid_timing_pkg;

    localparam int DOTPU_DEF = 8;
    localparam int HW_DEF    = 8;
    localparam int VW_DEF    = 10;
    localparam int DOT_W     = $clog2(DOTPU_DEF);
    localparam int LBUF_AW   = HW_DEF + DOT_W;

    // Field widths follow the default HW/VW; the top keeps its HW/VW at these defaults.
    typedef struct packed {
        logic [HW_DEF-1:0] htotal;
        logic [HW_DEF-1:0] hsynl;
        logic [HW_DEF-1:0] hvbgn;
        logic [HW_DEF-1:0] hvend;
        logic [VW_DEF-1:0] vtotal;
        logic [VW_DEF-1:0] vsynl;
        logic [VW_DEF-1:0] vvbgn;
        logic [VW_DEF-1:0] vvend;
    } timing_t;

    // Checkerboard in space, inverted every line and every frame.
    function automatic logic dither_phase(input logic sel, input logic par, input logic dot0);
        return sel ^ par ^ dot0;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Bundle between the CRTC register file / line buffer and the timing generator.
// There is no valid/ready here: pix_ce is the only qualifier. lbuf_adr is valid on
// every pix_ce, and the line buffer answers with pix_in one pix_ce later.
interface video_timing_gen_if #(
    parameter int DACRES = 4,
    parameter int INRES  = 6,
    parameter int HW     = vid_timing_pkg::HW_DEF,
    parameter int VW     = vid_timing_pkg::VW_DEF,
    parameter int DIVW   = 3,
    parameter int AW     = vid_timing_pkg::LBUF_AW
);
    logic [DIVW-1:0]       ce_div;
    logic [HW-1:0]         htotal;
    logic [HW-1:0]         hsynl;
    logic [HW-1:0]         hvbgn;
    logic [HW-1:0]         hvend;
    logic [VW-1:0]         vtotal;
    logic [VW-1:0]         vsynl;
    logic [VW-1:0]         vvbgn;
    logic [VW-1:0]         vvend;
    logic                  dither_en;
    logic [3*INRES-1:0]    pix_in;

    logic                  pix_ce;
    logic [AW-1:0]         lbuf_adr;
    logic                  lbuf_sel;
    logic                  hsync;
    logic                  vsync;
    logic                  hblank_n;
    logic                  vblank_n;
    logic                  de;
    logic                  hcomp;
    logic                  vcomp;
    logic                  vpstart;
    logic [3*DACRES-1:0]   rgb_out;

    modport master (
        input  ce_div, htotal, hsynl, hvbgn, hvend,
        input  vtotal, vsynl, vvbgn, vvend, dither_en, pix_in,
        output pix_ce, lbuf_adr, lbuf_sel, hsync, vsync, hblank_n, vblank_n,
        output de, hcomp, vcomp, vpstart, rgb_out
    );

    modport slave (
        output ce_div, htotal, hsynl, hvbgn, hvend,
        output vtotal, vsynl, vvbgn, vvend, dither_en, pix_in,
        input  pix_ce, lbuf_adr, lbuf_sel, hsync, vsync, hblank_n, vblank_n,
        input  de, hcomp, vcomp, vpstart, rgb_out
    );

endinterface

// File: rtl/video_dither.sv
// One colour channel: truncate INRES down to DACRES, rounding up on the active
// dither phase when the first dropped bit is set, without wrapping past full scale.
module video_dither #(
    parameter int INRES  = 6,
    parameter int DACRES = 4
) (
    input  logic [INRES-1:0]  i_din,
    input  logic              i_phase,
    output logic [DACRES-1:0] o_dout
);

    logic [DACRES-1:0] w_trunc;
    logic              w_frac;
    logic              w_unused;

    assign w_trunc  = i_din[INRES-1 -: DACRES];
    assign w_frac   = i_din[INRES-DACRES-1];
    assign w_unused = ^i_din;

    assign o_dout = (i_phase && w_frac && (w_trunc != '1)) ? w_trunc + 1'b1 : w_trunc;

endmodule

// File: rtl/video_timing_gen.sv
// Pixel CE divider, H/V counters with frame-boundary shadowing, sync/blank/DE
// decode, line-buffer addressing and a one-CE output pipeline with dithered RGB.
module video_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int DACRES = 4,
    parameter int INRES  = 6,
    parameter int DOTPU  = DOTPU_DEF,
    parameter int HW     = HW_DEF,
    parameter int VW     = VW_DEF,
    parameter int DIVW   = 3
) (
    input  logic             gclk,
    input  logic             rst,
    video_timing_gen_if.master bus
);

    localparam int DW = $clog2(DOTPU);

    timing_t             r_sh;
    logic [DIVW-1:0]     r_div_sh;
    logic [DIVW-1:0]     r_div_cnt;
    logic [DW-1:0]       r_dot;
    logic [HW-1:0]       r_hcnt;
    logic [VW-1:0]       r_vcnt;
    logic                r_lbuf_sel;
    logic                r_frame_par;
    logic                r_hcomp;
    logic                r_vcomp;
    logic                r_vpstart;
    logic                r_hsync;
    logic                r_vsync;
    logic                r_hblank_n;
    logic                r_vblank_n;
    logic                r_de;
    logic [3*DACRES-1:0] r_rgb;

    timing_t             w_timing_in;
    logic                w_pix_ce;
    logic                w_dot_wrap;
    logic                w_line_wrap;
    logic                w_frame_wrap;
    logic [VW-1:0]       w_vcnt_nxt;
    logic [VW-1:0]       w_vvbgn_nxt;
    logic                w_hact;
    logic                w_vact;
    logic [HW-1:0]       w_hrel;
    logic                w_phase;
    logic [3*DACRES-1:0] w_rgb_d;

    assign w_timing_in = '{htotal: bus.htotal, hsynl: bus.hsynl,
                           hvbgn:  bus.hvbgn,  hvend: bus.hvend,
                           vtotal: bus.vtotal, vsynl: bus.vsynl,
                           vvbgn:  bus.vvbgn,  vvend: bus.vvend};

    assign w_pix_ce     = (r_div_cnt == '0);
    assign w_dot_wrap   = (r_dot == DW'(DOTPU - 1));
    assign w_line_wrap  = w_dot_wrap && (r_hcnt >= r_sh.htotal);
    assign w_frame_wrap = w_line_wrap && (r_vcnt >= r_sh.vtotal);
    assign w_vcnt_nxt   = w_frame_wrap ? '0 : r_vcnt + 1'b1;
    // On the frame wrap the new shadow lands on the same edge, so compare against it.
    assign w_vvbgn_nxt  = w_frame_wrap ? bus.vvbgn : r_sh.vvbgn;

    assign w_hact  = (r_hcnt >= r_sh.hvbgn) && (r_hcnt < r_sh.hvend);
    assign w_vact  = (r_vcnt >= r_sh.vvbgn) && (r_vcnt < r_sh.vvend);
    assign w_hrel  = r_hcnt - r_sh.hvbgn;
    assign w_phase = bus.dither_en && dither_phase(r_lbuf_sel, r_frame_par, r_dot[0]);

    for (genvar c = 0; c < 3; c++) begin : g_ch
        video_dither #(.INRES(INRES), .DACRES(DACRES)) u_dither (
            .i_din   (bus.pix_in[c*INRES +: INRES]),
            .i_phase (w_phase),
            .o_dout  (w_rgb_d[c*DACRES +: DACRES])
        );
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            r_sh        <= w_timing_in;
            r_div_sh    <= bus.ce_div;
            r_div_cnt   <= '0;
            r_dot       <= '0;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_lbuf_sel  <= 1'b0;
            r_frame_par <= 1'b0;
            r_hcomp     <= 1'b0;
            r_vcomp     <= 1'b0;
            r_vpstart   <= 1'b0;
            r_hsync     <= 1'b0;
            r_vsync     <= 1'b0;
            r_hblank_n  <= 1'b0;
            r_vblank_n  <= 1'b0;
            r_de        <= 1'b0;
            r_rgb       <= '0;
        end else begin
            r_div_cnt <= (r_div_cnt >= r_div_sh) ? '0 : r_div_cnt + 1'b1;
            r_hcomp   <= w_pix_ce && w_line_wrap;
            r_vcomp   <= w_pix_ce && w_frame_wrap;
            r_vpstart <= w_pix_ce && w_line_wrap && (w_vcnt_nxt == w_vvbgn_nxt);
            if (w_pix_ce) begin
                // DOTPU is a power of two, so the dot counter wraps by itself.
                r_dot <= r_dot + 1'b1;
                if (w_dot_wrap) begin
                    if (r_hcnt >= r_sh.htotal) begin
                        r_hcnt     <= '0;
                        r_vcnt     <= w_vcnt_nxt;
                        r_lbuf_sel <= ~r_lbuf_sel;
                        if (w_frame_wrap) begin
                            r_frame_par <= ~r_frame_par;
                            r_sh        <= w_timing_in;
                            r_div_sh    <= bus.ce_div;
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                r_hsync    <= (r_hcnt < r_sh.hsynl);
                r_vsync    <= (r_vcnt < r_sh.vsynl);
                r_hblank_n <= w_hact;
                r_vblank_n <= w_vact;
                r_de       <= w_hact && w_vact;
                r_rgb      <= (w_hact && w_vact) ? w_rgb_d : '0;
            end
        end
    end

    assign bus.pix_ce   = w_pix_ce;
    assign bus.lbuf_adr = w_hact ? {w_hrel, r_dot} : '0;
    assign bus.lbuf_sel = r_lbuf_sel;
    assign bus.hsync    = r_hsync;
    assign bus.vsync    = r_vsync;
    assign bus.hblank_n = r_hblank_n;
    assign bus.vblank_n = r_vblank_n;
    assign bus.de       = r_de;
    assign bus.hcomp    = r_hcomp;
    assign bus.vcomp    = r_vcomp;
    assign bus.vpstart  = r_vpstart;
    assign bus.rgb_out  = r_rgb;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: reset, line/frame timing, divider,
// shadowing, dither, degenerate window and mid-line reset.
module tb_video_timing_gen;

    logic gclk = 1'b0;
    logic rst  = 1'b1;
    always #5 gclk = ~gclk;

    video_timing_gen_if #(.DACRES(4), .INRES(6), .HW(8), .VW(10), .DIVW(3), .AW(11)) bus ();

    video_timing_gen #(
        .DACRES(4), .INRES(6), .DOTPU(8), .HW(8), .VW(10), .DIVW(3)
    ) dut (
        .gclk (gclk),
        .rst  (rst),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int cfg_div  = 0;
    int cfg_ht   = 3;
    int cfg_hsl  = 1;
    int cfg_hb   = 1;
    int cfg_he   = 3;
    int cfg_vt   = 9;
    int cfg_vsl  = 2;
    int cfg_vb   = 2;
    int cfg_ve   = 8;
    int cfg_dith = 0;
    logic [5:0] pr = 6'b001110;
    logic [5:0] pg = 6'b101010;
    logic [5:0] pb = 6'b111111;

    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [3:0] rnd(input logic [5:0] v, input logic ph);
        logic [3:0] t;
        t = v[5:2];
        if (ph && v[1] && t != 4'hF) return t + 4'd1;
        return t;
    endfunction

    task automatic apply_cfg();
        bus.ce_div    = 3'(cfg_div);
        bus.htotal    = 8'(cfg_ht);
        bus.hsynl     = 8'(cfg_hsl);
        bus.hvbgn     = 8'(cfg_hb);
        bus.hvend     = 8'(cfg_he);
        bus.vtotal    = 10'(cfg_vt);
        bus.vsynl     = 10'(cfg_vsl);
        bus.vvbgn     = 10'(cfg_vb);
        bus.vvend     = 10'(cfg_ve);
        bus.dither_en = (cfg_dith != 0);
        bus.pix_in    = {pr, pg, pb};
    endtask

    // rst held for 3 edges; outputs checked after the last reset edge.
    task automatic do_reset();
        @(negedge gclk);
        rst = 1'b1;
        repeat (3) @(posedge gclk);
        @(negedge gclk);
        cyc = 0;
        check("rst_pix_ce",   bus.pix_ce,   1);
        check("rst_hsync",    bus.hsync,    0);
        check("rst_vsync",    bus.vsync,    0);
        check("rst_hblank_n", bus.hblank_n, 0);
        check("rst_vblank_n", bus.vblank_n, 0);
        check("rst_de",       bus.de,       0);
        check("rst_hcomp",    bus.hcomp,    0);
        check("rst_vcomp",    bus.vcomp,    0);
        check("rst_vpstart",  bus.vpstart,  0);
        check("rst_lbuf_sel", bus.lbuf_sel, 0);
        check("rst_lbuf_adr", bus.lbuf_adr, 0);
        check("rst_rgb",      bus.rgb_out,  0);
        rst = 1'b0;
    endtask

    // ce_div=0 reference: sample k follows edge k; outputs reflect counter state k-1.
    task automatic run_generic(input int n);
        int L, F, i, pos, hc, line, pc, hcc;
        logic de_e, ha_e, va_e, ph;
        logic [11:0] rgb_e;
        logic [31:0] adr_e;
        L = (cfg_ht + 1) * 8;
        F = L * (cfg_vt + 1);
        for (int k = 1; k <= n; k++) begin
            @(negedge gclk);
            cyc  = k;
            i    = k - 1;
            pos  = i % L;
            hc   = pos / 8;
            line = (i / L) % (cfg_vt + 1);
            ha_e = (hc >= cfg_hb) && (hc < cfg_he);
            va_e = (line >= cfg_vb) && (line < cfg_ve);
            de_e = ha_e && va_e;
            ph   = (cfg_dith != 0) && ((((i / L) + (i / F) + i) % 2) == 1);
            rgb_e = de_e ? {rnd(pr, ph), rnd(pg, ph), rnd(pb, ph)} : 12'h000;
            pc   = k % L;
            hcc  = pc / 8;
            adr_e = ((hcc >= cfg_hb) && (hcc < cfg_he)) ? 32'((hcc - cfg_hb) * 8 + pc % 8) : 32'd0;
            check("pix_ce",   bus.pix_ce,   1);
            check("de",       bus.de,       de_e);
            check("hblank_n", bus.hblank_n, ha_e);
            check("vblank_n", bus.vblank_n, va_e);
            check("hsync",    bus.hsync,    hc < cfg_hsl);
            check("vsync",    bus.vsync,    line < cfg_vsl);
            check("hcomp",    bus.hcomp,    (k % L) == 0);
            check("vcomp",    bus.vcomp,    (k % F) == 0);
            check("vpstart",  bus.vpstart,  ((k % L) == 0) && (((k / L) % (cfg_vt + 1)) == cfg_vb));
            check("lbuf_sel", bus.lbuf_sel, 32'((k / L) % 2));
            check("lbuf_adr", bus.lbuf_adr, adr_e);
            check("rgb_out",  bus.rgb_out,  rgb_e);
        end
    endtask

    initial begin
        apply_cfg();

        // Baseline: 32-CE lines, DE on dots 8..23 of active lines, no dither (rgb 3AF).
        do_reset();
        run_generic(330);

        // Degenerate window: no DE, no address, hsync still runs.
        cfg_he = 1;
        apply_cfg();
        do_reset();
        run_generic(330);
        cfg_he = 3;

        // Dither over two frames: R 3/4 checkerboard, G saturated at 15, B stays 0.
        cfg_dith = 1;
        pr = 6'b001110;
        pg = 6'b111110;
        pb = 6'b000001;
        apply_cfg();
        do_reset();
        run_generic(660);
        cfg_dith = 0;
        pr = 6'b001110;
        pg = 6'b101010;
        pb = 6'b111111;

        // Reset at hcnt=2 with a new hsync width pending on the inputs.
        apply_cfg();
        do_reset();
        run_generic(19);
        cfg_hsl = 2;
        apply_cfg();
        do_reset();
        run_generic(100);
        cfg_hsl = 1;

        // Divider: period 3 for the whole first frame, 2 after its wrap (CE #319 at k=957).
        cfg_div = 2;
        apply_cfg();
        do_reset();
        for (int k = 1; k <= 1000; k++) begin
            @(negedge gclk);
            cyc = k;
            check("div_ce", bus.pix_ce, (k <= 957) ? ((k % 3) == 0) : (((k - 957) % 2) == 0));
            check("div_vcomp", bus.vcomp, k == 958);
            if (k == 100) bus.ce_div = 3'd1;
        end

        // Shadowing: vtotal 9 -> 5 written during line 4; frames of 10 then 6 lines.
        cfg_div = 0;
        apply_cfg();
        do_reset();
        exp_q.push_back(32'd320);
        exp_q.push_back(32'd512);
        exp_q.push_back(32'd704);
        for (int k = 1; k <= 720; k++) begin
            @(negedge gclk);
            cyc = k;
            check("sh_hcomp", bus.hcomp, (k % 32) == 0);
            check("sh_vpstart", bus.vpstart, (k == 64) || (k == 384) || (k == 576));
            if (bus.vcomp) check("sh_vcomp_at", 32'(k), (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0);
            if (k == 140) bus.vtotal = 10'd5;
        end
        check("sh_vcomp_left", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed X68000 CRTC timing/sync generator.
- Generates the pixel clock-enable, horizontal and vertical counters, sync, blank and DE, line-buffer addressing and ping-pong select, and a dithered DAC output.
- Programmable pixel divider, configurable character-unit width and channel depths.
- Timing registers are shadowed and take effect only at frame boundaries.
- Sits between the CRTC register file / line buffer and the MiSTer video output.

Parameters:
- DACRES, 4: output bits per colour channel.
- INRES, 6: input bits per channel; must be > DACRES.
- DOTPU, 8: dots per character unit; power of two, 2..16.
- HW, 8: width of horizontal timing registers (character units).
- VW, 10: width of vertical timing registers (lines).
- DIVW, 3: width of the pixel divider field.

Ports:
- gclk  in  1  system clock; only clock.
- rst  in  1  reset, synchronous, active-high.
- ce_div  in  DIVW  pixel CE period minus 1 (CE every ce_div+1 gclk cycles).
- htotal, hsynl, hvbgn, hvend  in  HW each  line length−1, hsync end, active begin, active end.
- vtotal, vsynl, vvbgn, vvend  in  VW each  frame length−1, vsync end, active begin, active end.
- dither_en  in  1  enable the rounding dither.
- pix_in  in  3*INRES  {R,G,B} from the line buffer.
- pix_ce  out  1  pixel clock-enable.
- lbuf_adr  out  HW+log2(DOTPU)  active pixel index within the line.
- lbuf_sel  out  1  line ping-pong select.
- hsync, vsync  out  1 each  sync, active-high.
- hblank_n, vblank_n  out  1 each  active region, horizontal and vertical.
- de  out  1  data enable, aligned with rgb_out.
- hcomp, vcomp  out  1 each  one-gclk pulse at line end / frame end.
- vpstart  out  1  one-gclk pulse at the start of line vvbgn.
- rgb_out  out  3*DACRES  dithered colour.

Behaviour:
- Reset (rst on any gclk edge, including mid-frame):
  - All counters, lbuf_sel, frame parity and the output pipeline clear.
  - Shadow registers load directly from the inputs.
  - All outputs are 0, except pix_ce = 1 on the first cycle after reset.
- Divider:
  - div_cnt counts 0..ce_div_shadow; pix_ce is asserted when div_cnt==0.
  - ce_div=0 gives pix_ce every cycle.
  - ce_div is shadowed per frame.
- Counters advance only on pix_ce:
  - dot counts 0..DOTPU-1.
  - On dot wrap, hcnt increments.
  - When hcnt>=htotal_s, hcnt goes to 0 and vcnt increments; a line is htotal+1 units.
  - When vcnt>=vtotal_s, vcnt goes to 0 and the frame ends.
- Shadow registers: all timing inputs are captured on the pix_ce that wraps vcnt to 0. Mid-frame changes do not affect the current frame.
- Decodes (shadow values, internal):
  - hact = hvbgn_s<=hcnt<hvend_s; vact likewise.
  - hsync = hcnt<hsynl_s; vsync = vcnt<vsynl_s.
  - If hvend<=hvbgn there is no active region, so de stays 0.
- lbuf_adr:
  - = {hcnt-hvbgn_s, dot} while hact; 0 otherwise.
  - Pixel data arrives one pix_ce later.
- Pulses:
  - hcomp: one gclk high on the cycle after the line-wrap pix_ce.
  - vcomp: same timing, after the frame wrap.
  - lbuf_sel toggles at the same edge as hcomp; frame parity toggles with vcomp.
  - vpstart = hcomp && (new vcnt==vvbgn_s).
- Output pipeline (one pix_ce latency): hsync, vsync, hblank_n, vblank_n and de are registered on pix_ce together with rgb_out.
- Dither, per channel, where trunc = top DACRES bits of the input and f = the next bit down:
  - If dither_en && (lbuf_sel ^ frame_par ^ dot[0]) && f && trunc!=all-ones, output trunc+1.
  - Otherwise output trunc.
  - No wrap past full scale.
  - When de (pipelined) is 0, rgb_out = 0.
- Simultaneous line wrap and frame wrap: vcomp and hcomp fire together, and the shadow load occurs on that same pix_ce.

Decomposition:
- Package vid_timing_pkg:
  - typedef timing_t, a struct of the eight timing fields.
  - dither-phase function.
  - constants DOT_W = $clog2(DOTPU) and LBUF_AW.
- One sub-module, video_dither: a combinational per-channel rounding block parametrised by INRES/DACRES, instantiated 3×.

Test Plan:
- Reset/defaults:
  - Stimulus: rst high 3 cycles, then released, with ce_div=0, htotal=3, hvbgn=1, hvend=3, hsynl=1, DOTPU=8.
  - Required: line = 32 pix_ce; de high for pix_ce 9..24 of each line, one CE late; hcomp every 32 gclk.
- Divider:
  - Stimulus: ce_div=2.
  - Required: pix_ce 1-in-3 gclk.
  - Stimulus: change ce_div to 1 mid-frame.
  - Required: period stays 3 until the next vcomp, then 2.
- Shadowing:
  - Stimulus: write vtotal 9→5 on line 4.
  - Required: the current frame completes 10 lines; the next frame has 6; vpstart fires at vvbgn each frame.
- Dither:
  - Stimulus: INRES=6, DACRES=4, pix_in R=6'b001110, dither_en=1.
  - Required: outputs alternate 3/4 per dot; the phase inverts per line and per frame.
  - Stimulus: R=6'b111110.
  - Required: output stays 15.
- Degenerate window:
  - Stimulus: hvend=hvbgn.
  - Required: de never asserts, rgb_out 0, lbuf_adr 0; hsync still toggles.
- Reset mid-line:
  - Stimulus: rst asserted at hcnt=2.
  - Required: all outputs 0 next cycle; the counters restart from 0 with the new shadow values.
